// File: rtl/dyn_link_input_buffer.sv
// rtl/dyn_link_input_buffer.sv - credit-based link input FIFO with optional bit-inversion restore
module dyn_link_input_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 2,
  parameter int INVERT_IN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  yummy_out,
  output logic                  data_val,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  thanks_in,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow_err
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0] capture_data;
  logic                  full;
  logic                  enq;
  logic                  deq;
  logic                  drop;

  // Undo the link's wire inversion before the flit is stored
  assign capture_data = (INVERT_IN != 0) ? ~data_in : data_in;

  // Handshake decode; a full buffer still accepts when the head leaves in the same cycle
  always_comb begin
    full     = (count == FULL_COUNT);
    data_val = (count != '0);
    deq      = thanks_in & data_val;
    enq      = valid_in & (~full | deq);
    drop     = valid_in & full & ~deq;
    data_out = data_val ? mem[rd_ptr] : '0;
  end

  // Flit storage, intentionally not reset; data_out masks it while empty
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      mem[wr_ptr] <= capture_data;
    end
  end

  // Pointers, occupancy, sticky overflow and registered credit return
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      yummy_out    <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow_err <= 1'b1;
      end
      yummy_out <= deq;
    end
  end

endmodule

// File: tb/tb_dyn_link_input_buffer.sv
// tb/tb_dyn_link_input_buffer.sv - scoreboard bench for dyn_link_input_buffer
module tb_dyn_link_input_buffer;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        thanks_in;
  logic [63:0] data_in;

  logic        yummy_out_a, data_val_a, overflow_err_a;
  logic [63:0] data_out_a;
  logic [2:0]  count_a;
  logic        yummy_out_b, data_val_b, overflow_err_b;
  logic [63:0] data_out_b;
  logic [2:0]  count_b;

  logic [63:0] exp_q [$];
  int          cur_cnt;
  bit          cur_ovf;
  bit          cur_y;
  bit          checking;
  int          n_cmp;
  int          n_bad;
  int          deq_total;
  int          pulse_total;

  dyn_link_input_buffer #(.DATA_WIDTH(64), .DEPTH_LOG2(2), .INVERT_IN(1)) dut_a (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .yummy_out(yummy_out_a), .data_val(data_val_a), .data_out(data_out_a),
    .thanks_in(thanks_in), .count(count_a), .overflow_err(overflow_err_a)
  );

  dyn_link_input_buffer #(.DATA_WIDTH(64), .DEPTH_LOG2(2), .INVERT_IN(0)) dut_b (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .yummy_out(yummy_out_b), .data_val(data_val_b), .data_out(data_out_b),
    .thanks_in(thanks_in), .count(count_b), .overflow_err(overflow_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model decides what the edge should do
  task automatic cycle(input logic v, input logic [63:0] d, input logic t, input logic r);
    int  nxt_cnt;
    bit  nxt_ovf, nxt_y, clr, deq, enq;
    reset     = r;
    valid_in  = v;
    data_in   = d;
    thanks_in = t;
    clr       = 1'b0;
    if (r) begin
      nxt_cnt = 0;
      nxt_ovf = 1'b0;
      nxt_y   = 1'b0;
      clr     = 1'b1;
    end else begin
      deq = t && (cur_cnt > 0);
      enq = v && ((cur_cnt < 4) || deq);
      if (enq) exp_q.push_back(d);
      if (deq) deq_total++;
      nxt_cnt = cur_cnt + (enq ? 1 : 0) - (deq ? 1 : 0);
      nxt_ovf = cur_ovf || (v && (cur_cnt == 4) && !deq);
      nxt_y   = deq;
    end
    @(posedge clk);
    #1;
    if (clr) begin
      exp_q.delete();
      checking = 1'b1;
    end
    cur_cnt = nxt_cnt;
    cur_ovf = nxt_ovf;
    cur_y   = nxt_y;
  endtask

  // Monitor: compare outputs every cycle, pop the scoreboard when the head is consumed
  always @(negedge clk) begin
    if (checking) begin
      chk("count_a", 64'(count_a), 64'(cur_cnt));
      chk("count_b", 64'(count_b), 64'(cur_cnt));
      chk("data_val_a", 64'(data_val_a), 64'(cur_cnt != 0));
      chk("data_val_b", 64'(data_val_b), 64'(cur_cnt != 0));
      chk("overflow_a", 64'(overflow_err_a), 64'(cur_ovf));
      chk("overflow_b", 64'(overflow_err_b), 64'(cur_ovf));
      chk("yummy_a", 64'(yummy_out_a), 64'(cur_y));
      chk("yummy_b", 64'(yummy_out_b), 64'(cur_y));
      if (cur_cnt > 0 && exp_q.size() > 0) begin
        chk("head_a", data_out_a, ~exp_q[0]);
        chk("head_b", data_out_b, exp_q[0]);
      end else begin
        chk("idle_out_a", data_out_a, 64'h0);
        chk("idle_out_b", data_out_b, 64'h0);
      end
      if (yummy_out_a) pulse_total++;
      if (data_val_a && thanks_in && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; thanks_in = 1'b0; data_in = '0;
    checking = 1'b0; cur_cnt = 0; cur_ovf = 1'b0; cur_y = 1'b0;
    n_cmp = 0; n_bad = 0; deq_total = 0; pulse_total = 0;

    cycle(0, 64'h0, 0, 1);
    cycle(0, 64'h0, 0, 1);
    chk("reset_count", 64'(count_a), 64'h0);
    chk("reset_val", 64'(data_val_a), 64'h0);
    cycle(0, 64'h0, 0, 0);

    cycle(1, 64'hFFFF_FFFF_0000_0000, 0, 0);
    chk("single_data", data_out_a, 64'h0000_0000_FFFF_FFFF);
    chk("single_count", 64'(count_a), 64'd1);
    cycle(0, 64'h0, 1, 0);
    chk("single_yummy", 64'(yummy_out_a), 64'd1);
    chk("single_empty", 64'(count_a), 64'd0);
    chk("single_zero", data_out_a, 64'h0);
    cycle(0, 64'h0, 0, 0);

    for (int i = 0; i < 5; i++) cycle(1, 64'hA0 + 64'(i), 0, 0);
    chk("ovf_flag", 64'(overflow_err_a), 64'd1);
    chk("ovf_count", 64'(count_a), 64'd4);
    chk("ovf_head", data_out_a, ~64'hA0);
    for (int i = 0; i < 6; i++) cycle(0, 64'h0, 1, 0);
    cycle(0, 64'h0, 0, 0);

    cycle(0, 64'h0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 64'hB0 + 64'(i), 0, 0);
    cycle(1, 64'hB4, 1, 0);
    chk("full_both_count", 64'(count_a), 64'd4);
    chk("full_both_ovf", 64'(overflow_err_a), 64'd0);
    chk("full_both_yummy", 64'(yummy_out_a), 64'd1);
    chk("full_both_head", data_out_a, ~64'hB1);
    for (int i = 0; i < 5; i++) cycle(0, 64'h0, 1, 0);
    cycle(0, 64'h0, 0, 0);

    for (int i = 0; i < 10; i++) cycle(1, 64'hC0 + 64'(i), 1, 0);
    cycle(0, 64'h0, 1, 0);
    cycle(0, 64'h0, 0, 0);

    for (int i = 0; i < 5; i++) cycle(1, 64'hD0 + 64'(i), 0, 0);
    cycle(0, 64'h0, 1, 0);
    chk("mid_count", 64'(count_a), 64'd3);
    chk("mid_ovf", 64'(overflow_err_a), 64'd1);
    cycle(1, 64'hDEAD, 1, 1);
    chk("rst_count", 64'(count_a), 64'd0);
    chk("rst_val", 64'(data_val_a), 64'd0);
    chk("rst_ovf", 64'(overflow_err_a), 64'd0);
    chk("rst_yummy", 64'(yummy_out_a), 64'd0);

    cycle(1, 64'h1234, 0, 0);
    chk("pass_b", data_out_b, 64'h1234);
    chk("inv_a", data_out_a, ~64'h1234);
    cycle(0, 64'h0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      int thr;
      thr = ((i / 100) % 2 == 0) ? 30 : 80;
      cycle(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
            {$urandom, $urandom},
            ($urandom_range(0, 99) < thr) ? 1'b1 : 1'b0,
            ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 6; i++) cycle(0, 64'h0, 1, 0);
    cycle(0, 64'h0, 0, 0);
    cycle(0, 64'h0, 0, 0);
    chk("credit_total", 64'(pulse_total), 64'(deq_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dyn_link_input_buffer.md
DYN_LINK_INPUT_BUFFER -- requirements
Module: dyn_link_input_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: flit width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 2: log2 of the number of buffer entries (4 entries by default).
REQ-003 SHALL have parameter INVERT_IN, default 1: 1 means link data arrives bit-inverted and is restored on capture; 0 means it is stored as received.
REQ-004 SHALL have port clk  input  1  the single clock, with all state updated on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid_in  input  1  a link flit is present this cycle.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  link flit, possibly inverted.
REQ-008 SHALL have port yummy_out  output  1  credit return to the upstream router, one pulse per consumed flit.
REQ-009 SHALL have port data_val  output  1  the head entry is valid.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  the head entry, always non-inverted.
REQ-011 SHALL have port thanks_in  input  1  the consumer accepts the head entry this cycle.
REQ-012 SHALL have port count  output  DEPTH_LOG2+1  the current occupancy.
REQ-013 SHALL have port overflow_err  output  1  sticky flag: a flit was dropped.

Function
REQ-014 SHALL store ~data_in when INVERT_IN=1, and data_in otherwise.
REQ-015 SHALL be a circular FIFO of 2^DEPTH_LOG2 entries, with read and write pointers of DEPTH_LOG2 bits that wrap modulo depth.
REQ-016 SHALL enqueue on any cycle with valid_in=1 when the FIFO is not full (count < depth), writing at the write pointer and then incrementing it.
REQ-017 SHALL dequeue on any cycle with thanks_in=1 and data_val=1, incrementing the read pointer.
REQ-018 SHALL ignore thanks_in when data_val=0: no pointer move and no credit.
REQ-019 SHALL give 1-cycle latency: a flit enqueued into an empty FIFO at edge N appears as data_val=1 with data_out valid in the cycle after edge N.
REQ-020 SHALL drive data_val combinationally from count != 0, and SHALL drive data_out as the head entry when data_val=1 and as all-zeros when data_val=0.
REQ-021 SHALL, on a simultaneous enqueue and dequeue, perform both and leave count unchanged; this SHALL also hold when full.
REQ-022 SHALL, when full, treat valid_in=1 with no dequeue that cycle as an overflow: the flit is dropped, storage and pointers are unchanged, and overflow_err is set to 1 at the next edge.
REQ-023 SHALL keep overflow_err at 1 once set, until reset.
REQ-024 SHALL update count as +1 on enqueue only, -1 on dequeue only, and unchanged when both or neither occur; count SHALL never exceed depth and never go below 0.
REQ-025 SHALL register yummy_out: it is 1 in exactly the cycle after each dequeue and 0 otherwise, so back-to-back dequeues give back-to-back pulses.
REQ-026 SHALL return exactly one credit per dequeued flit; dropped flits SHALL return no credit.
REQ-027 SHALL have no combinational path from valid_in or data_in to any output.

Reset
REQ-028 SHALL, while reset=1 at a rising edge, clear both pointers, count, overflow_err and yummy_out to 0; data_val and data_out are therefore 0 in the following cycle.
REQ-029 SHALL give reset priority over a simultaneous valid_in or thanks_in: no enqueue, no dequeue, and no yummy_out pulse after the reset edge.
REQ-030 SHALL leave storage contents unreset; they SHALL never be observable on data_out while data_val=0.
REQ-031 SHALL accept an enqueue on the first edge after reset deasserts.

Verification
REQ-032 SHALL cover single flit: INVERT_IN=1, valid_in=1 with data_in=64'hFFFF_FFFF_0000_0000 for 1 cycle -> next cycle data_val=1, data_out=64'h0000_0000_FFFF_FFFF, count=1; thanks_in=1 -> yummy_out=1 for one cycle, count=0, data_out=0.
REQ-033 SHALL cover fill and overflow: 5 consecutive valid_in with no thanks_in, depth 4 -> count=4 and overflow_err=1 after the 5th; the head is still the 1st flit; draining yields flits 1-4 in order and exactly 4 yummy_out pulses.
REQ-034 SHALL cover full with simultaneous enqueue and dequeue: count=4, valid_in=1 and thanks_in=1 -> count stays 4, overflow_err stays 0, one yummy_out pulse, and the new flit lands last.
REQ-035 SHALL cover wrap-around: 10 flits streamed with thanks_in held at 1 -> in-order output with no loss, count<=1 throughout, and 10 yummy_out pulses.
REQ-036 SHALL cover reset mid-operation: count=3, overflow_err=1, then reset=1 together with thanks_in=1 -> next cycle count=0, data_val=0, overflow_err=0, and no yummy_out pulse.
REQ-037 SHALL cover pass-through mode: INVERT_IN=0, data_in=64'h1234 -> data_out=64'h1234.
